// File: rtl/led_scan_sequencer.sv
// led_scan_sequencer: drives a bank of PWM fader channels with a scanning lit position.
// Steps the position every step_period cycles in wrap-up, bounce, wrap-down or hold mode.
// Brightness arrives through a one-entry shadow register and is applied only on step
// boundaries, so the shared width never changes mid-step.
// Optional macro LED_GAMMA_EN: square-law gamma on the applied brightness, one cycle later.

module led_scan_sequencer #(
   parameter int unsigned NUM_LEDS = 8,
   parameter int unsigned POS_W    = 5
) (
   input  logic                clk,
   input  logic                RESET_N,
   input  logic                enable,
   input  logic [1:0]          mode,
   input  logic [23:0]         step_period,
   input  logic                cfg_valid,
   input  logic [7:0]          cfg_brightness,
   output logic                cfg_ready,
   output logic [NUM_LEDS-1:0] selected,
   output logic [7:0]          pwm_width_full,
   output logic [POS_W-1:0]    position,
   output logic                busy,
   output logic                sweep_done
);

   localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LEDS - 1);
   localparam logic [1:0] MODE_UP     = 2'b00;
   localparam logic [1:0] MODE_BOUNCE = 2'b01;
   localparam logic [1:0] MODE_DOWN   = 2'b10;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOPPING} state_e;

   state_e              state_q, state_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic                dir_q, dir_d;
   logic [23:0]         presc_q, presc_d;
   logic [NUM_LEDS-1:0] sel_q, sel_d;
   logic                busy_q, busy_d;
   logic                sweep_q, sweep_d;
   logic [7:0]          shadow_q, shadow_d;
   logic                full_q, full_d;
   logic                ready_q, ready_d;
   logic [7:0]          bright_q, bright_d;

   logic [23:0]         period_eff_c;
   logic                tick_c;
   logic                xfer_c;
   logic                apply_c;
   logic [POS_W-1:0]    next_pos_c;
   logic                next_dir_c;
   logic                low_end_c;

   // Terminal-count compare also catches a step_period that shrank below the count
   always_comb begin
      period_eff_c = (step_period == 24'd0) ? 24'd1 : step_period;
      tick_c       = (state_q != ST_IDLE) && (presc_q >= (period_eff_c - 24'd1));
   end

   // Next position, direction and low-end event for a step in the current mode
   always_comb begin
      next_pos_c = pos_q;
      next_dir_c = dir_q;
      low_end_c  = 1'b0;
      case (mode)
         MODE_UP: begin
            if (pos_q == POS_MAX) begin
               next_pos_c = '0;
               low_end_c  = 1'b1;
            end else begin
               next_pos_c = pos_q + POS_W'(1);
            end
         end
         MODE_DOWN: begin
            if (pos_q == '0) begin
               next_pos_c = POS_MAX;
               low_end_c  = 1'b1;
            end else begin
               next_pos_c = pos_q - POS_W'(1);
            end
         end
         MODE_BOUNCE: begin
            if (NUM_LEDS == 1) begin
               next_pos_c = '0;
               low_end_c  = 1'b1;
            end else if (dir_q) begin
               if (pos_q == POS_MAX) begin
                  next_dir_c = 1'b0;
                  next_pos_c = pos_q - POS_W'(1);
               end else begin
                  next_pos_c = pos_q + POS_W'(1);
               end
            end else begin
               if (pos_q == '0) begin
                  next_dir_c = 1'b1;
                  next_pos_c = pos_q + POS_W'(1);
               end else begin
                  next_pos_c = pos_q - POS_W'(1);
                  low_end_c  = (pos_q == POS_W'(1));
               end
            end
         end
         default: next_pos_c = pos_q;
      endcase
   end

   // Scan FSM, prescaler and config shadow next-state logic
   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      dir_d    = dir_q;
      presc_d  = presc_q;
      sweep_d  = 1'b0;
      shadow_d = shadow_q;
      full_d   = full_q;
      bright_d = bright_q;

      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_RUN;
               presc_d = '0;
               pos_d   = (mode == MODE_DOWN) ? POS_MAX : '0;
               dir_d   = 1'b1;
            end
         end
         ST_RUN: begin
            presc_d = tick_c ? 24'd0 : presc_q + 24'd1;
            if (!enable) begin
               state_d = ST_STOPPING;
            end else if (tick_c) begin
               pos_d   = next_pos_c;
               dir_d   = next_dir_c;
               sweep_d = low_end_c;
            end
         end
         ST_STOPPING: begin
            presc_d = tick_c ? 24'd0 : presc_q + 24'd1;
            if (enable) begin
               state_d = ST_RUN;
            end else if (tick_c) begin
               state_d = ST_IDLE;
               pos_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            pos_d   = '0;
            presc_d = '0;
         end
      endcase

      xfer_c  = cfg_valid && ready_q;
      apply_c = full_q && ((state_q == ST_IDLE) || tick_c);
      if (apply_c) begin
         bright_d = shadow_q;
         full_d   = 1'b0;
      end
      if (xfer_c) begin
         shadow_d = cfg_brightness;
         full_d   = 1'b1;
      end
      ready_d = !full_d;

      busy_d = (state_d != ST_IDLE);
      sel_d  = busy_d ? (NUM_LEDS'(1) << pos_d) : '0;
   end

   // State and output registers
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= ST_IDLE;
         pos_q    <= '0;
         dir_q    <= 1'b1;
         presc_q  <= '0;
         sel_q    <= '0;
         busy_q   <= 1'b0;
         sweep_q  <= 1'b0;
         shadow_q <= '0;
         full_q   <= 1'b0;
         ready_q  <= 1'b1;
         bright_q <= 8'hFF;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         dir_q    <= dir_d;
         presc_q  <= presc_d;
         sel_q    <= sel_d;
         busy_q   <= busy_d;
         sweep_q  <= sweep_d;
         shadow_q <= shadow_d;
         full_q   <= full_d;
         ready_q  <= ready_d;
         bright_q <= bright_d;
      end
   end

`ifdef LED_GAMMA_EN
   logic [15:0] sq_c;
   logic [7:0]  pwm_q, pwm_d;

   // Square-law gamma of the applied brightness
   always_comb begin
      sq_c  = 16'(bright_q) * 16'(bright_q);
      pwm_d = sq_c[15:8];
   end

   // Gamma output register
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) pwm_q <= 8'hFE;
      else          pwm_q <= pwm_d;
   end

   assign pwm_width_full = pwm_q;
`else
   assign pwm_width_full = bright_q;
`endif

   assign cfg_ready  = ready_q;
   assign selected   = sel_q;
   assign position   = pos_q;
   assign busy       = busy_q;
   assign sweep_done = sweep_q;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Directed bench for led_scan_sequencer: an 8-channel instance and a 1-channel instance.
module tb_led_scan_sequencer;

`ifdef LED_GAMMA_EN
   localparam bit         GAMMA   = 1'b1;
   localparam logic [7:0] PWM_RST = 8'hFE;
`else
   localparam bit         GAMMA   = 1'b0;
   localparam logic [7:0] PWM_RST = 8'hFF;
`endif
   localparam logic [7:0] G40 = GAMMA ? 8'h10 : 8'h40;
   localparam logic [7:0] G80 = GAMMA ? 8'h40 : 8'h80;

   logic clk = 1'b0;
   logic rst_n_i;
   always #5 clk = ~clk;

   // 8-channel instance
   logic        en8, cv8;
   logic [1:0]  md8;
   logic [23:0] per8;
   logic [7:0]  cb8;
   logic        ready8, busy8, sw8;
   logic [7:0]  sel8, pwm8;
   logic [4:0]  pos8;

   // 1-channel instance
   logic        en1, cv1;
   logic [1:0]  md1;
   logic [23:0] per1;
   logic [7:0]  cb1;
   logic        ready1, busy1, sw1;
   logic [0:0]  sel1, pos1;
   logic [7:0]  pwm1;

   led_scan_sequencer #(.NUM_LEDS(8), .POS_W(5)) dut8 (
      .clk(clk), .RESET_N(rst_n_i), .enable(en8), .mode(md8), .step_period(per8),
      .cfg_valid(cv8), .cfg_brightness(cb8), .cfg_ready(ready8), .selected(sel8),
      .pwm_width_full(pwm8), .position(pos8), .busy(busy8), .sweep_done(sw8));

   led_scan_sequencer #(.NUM_LEDS(1), .POS_W(1)) dut1 (
      .clk(clk), .RESET_N(rst_n_i), .enable(en1), .mode(md1), .step_period(per1),
      .cfg_valid(cv1), .cfg_brightness(cb1), .cfg_ready(ready1), .selected(sel1),
      .pwm_width_full(pwm1), .position(pos1), .busy(busy1), .sweep_done(sw1));

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic        en;
      logic [23:0] per;
      logic [4:0]  pos;
      logic        busy;
      logic        sweep;
   } vec_t;

   vec_t tbl[46];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk8(input string nm, input int pos, input logic bsy, input logic swp);
      logic [31:0] esel;
      esel = bsy ? (32'd1 << pos) : 32'd0;
      chk({nm, ".pos"},   32'(pos8),  32'(pos));
      chk({nm, ".sel"},   32'(sel8),  esel);
      chk({nm, ".busy"},  32'(busy8), 32'(bsy));
      chk({nm, ".sweep"}, 32'(sw8),   32'(swp));
   endtask

   task automatic do_reset();
      rst_n_i = 1'b0;
      en8 = 1'b0; md8 = 2'b00; per8 = 24'd1; cv8 = 1'b0; cb8 = 8'h00;
      en1 = 1'b0; md1 = 2'b00; per1 = 24'd1; cv1 = 1'b0; cb1 = 8'h00;
      cyc();
      cyc();
      rst_n_i = 1'b1;
      cyc();
   endtask

   function automatic vec_t mk(input logic en, input int pos, input logic bsy, input logic swp);
      vec_t v;
      v.en = en; v.per = 24'd3; v.pos = 5'(pos); v.busy = bsy; v.sweep = swp;
      return v;
   endfunction

   initial begin
      int bseq[16];
      bseq = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

      // Stop / resume table, step_period=3, mode wrap-up
      for (int k = 0; k < 16; k++) tbl[k] = mk(1'b1, k / 3, 1'b1, 1'b0);
      tbl[16] = mk(1'b0, 5, 1'b1, 1'b0);
      tbl[17] = mk(1'b0, 5, 1'b1, 1'b0);
      tbl[18] = mk(1'b0, 0, 1'b0, 1'b0);
      tbl[19] = mk(1'b0, 0, 1'b0, 1'b0);
      for (int k = 20; k < 36; k++) tbl[k] = mk(1'b1, (k - 20) / 3, 1'b1, 1'b0);
      tbl[36] = mk(1'b0, 5, 1'b1, 1'b0);
      tbl[37] = mk(1'b1, 5, 1'b1, 1'b0);
      for (int k = 38; k < 41; k++) tbl[k] = mk(1'b1, 6, 1'b1, 1'b0);
      for (int k = 41; k < 44; k++) tbl[k] = mk(1'b1, 7, 1'b1, 1'b0);
      tbl[44] = mk(1'b1, 0, 1'b1, 1'b1);
      tbl[45] = mk(1'b1, 0, 1'b1, 1'b0);

      // Reset values while reset is held
      rst_n_i = 1'b0;
      en8 = 1'b0; md8 = 2'b00; per8 = 24'd1; cv8 = 1'b0; cb8 = 8'h00;
      en1 = 1'b0; md1 = 2'b00; per1 = 24'd1; cv1 = 1'b0; cb1 = 8'h00;
      #12;
      chk8("rst", 0, 1'b0, 1'b0);
      chk("rst.ready", 32'(ready8), 32'd1);
      chk("rst.pwm",   32'(pwm8),   32'(PWM_RST));
      chk("rst1.pwm",  32'(pwm1),   32'(PWM_RST));

      // Table-driven stop / resume sequence
      do_reset();
      for (int i = 0; i < 46; i++) begin
         en8 = tbl[i].en; md8 = 2'b00; per8 = tbl[i].per;
         cyc();
         chk8($sformatf("tbl[%0d]", i), int'(tbl[i].pos), tbl[i].busy, tbl[i].sweep);
         chk($sformatf("tbl[%0d].ready", i), 32'(ready8), 32'd1);
         chk($sformatf("tbl[%0d].pwm", i),   32'(pwm8),   32'(PWM_RST));
      end

      // Wrap-up, step_period=4: each position held 4 cycles, sweep after 7->0
      do_reset();
      md8 = 2'b00; per8 = 24'd4; en8 = 1'b1;
      for (int k = 0; k < 36; k++) begin
         cyc();
         chk8($sformatf("wrap[%0d]", k), (k / 4) % 8, 1'b1, k == 32);
      end

      // Bounce, step_period=1: single dwell at both ends, sweep after 1->0
      do_reset();
      md8 = 2'b01; per8 = 24'd1; en8 = 1'b1;
      for (int k = 0; k < 16; k++) begin
         cyc();
         chk8($sformatf("bounce[%0d]", k), bseq[k], 1'b1, k == 14);
      end

      // Wrap-down, step_period=1: starts at 7, sweep after 0->7
      do_reset();
      md8 = 2'b10; per8 = 24'd1; en8 = 1'b1;
      for (int k = 0; k < 9; k++) begin
         cyc();
         chk8($sformatf("down[%0d]", k), (k == 8) ? 7 : 7 - k, 1'b1, k == 8);
      end

      // step_period shrinks below the running count: immediate tick
      do_reset();
      md8 = 2'b00; per8 = 24'd10; en8 = 1'b1;
      for (int k = 0; k < 6; k++) cyc();
      chk8("shrink.before", 0, 1'b1, 1'b0);
      per8 = 24'd2;
      cyc(); chk8("shrink.tick", 1, 1'b1, 1'b0);
      cyc(); chk8("shrink.hold", 1, 1'b1, 1'b0);
      cyc(); chk8("shrink.next", 2, 1'b1, 1'b0);

      // Config handshake in RUN (hold mode, step_period=4)
      do_reset();
      md8 = 2'b11; per8 = 24'd4; en8 = 1'b1;
      cyc();
      cv8 = 1'b1; cb8 = 8'h40;
      cyc();
      chk("cfg.e1.ready", 32'(ready8), 32'd0);
      chk("cfg.e1.pwm",   32'(pwm8),   32'(PWM_RST));
      cb8 = 8'h22;
      cyc();
      chk("cfg.e2.ready", 32'(ready8), 32'd0);
      chk("cfg.e2.pwm",   32'(pwm8),   32'(PWM_RST));
      cyc();
      chk("cfg.e3.ready", 32'(ready8), 32'd0);
      chk("cfg.e3.pwm",   32'(pwm8),   32'(PWM_RST));
      cyc();
      chk("cfg.tick.ready", 32'(ready8), 32'd1);
      chk("cfg.tick.pwm",   32'(pwm8),   32'(GAMMA ? PWM_RST : 8'h40));
      cv8 = 1'b0;
      cyc();
      chk("cfg.after.pwm",   32'(pwm8),  32'(G40));
      chk("cfg.after.ready", 32'(ready8), 32'd1);
      chk8("cfg.hold", 0, 1'b1, 1'b0);

      // Config apply while IDLE happens on the following cycle
      en8 = 1'b0;
      cyc(); cyc(); cyc();
      chk("idle.busy", 32'(busy8), 32'd0);
      cv8 = 1'b1; cb8 = 8'h80;
      cyc();
      chk("idle.xfer.ready", 32'(ready8), 32'd0);
      chk("idle.xfer.pwm",   32'(pwm8),   32'(G40));
      cv8 = 1'b0;
      cyc();
      chk("idle.apply.ready", 32'(ready8), 32'd1);
      chk("idle.apply.pwm",   32'(pwm8),   32'(GAMMA ? G40 : 8'h80));
      cyc();
      chk("idle.final.pwm", 32'(pwm8), 32'(G80));

      // Asynchronous reset mid-RUN with a pending shadow value
      do_reset();
      md8 = 2'b00; per8 = 24'd3; en8 = 1'b1;
      for (int k = 0; k < 4; k++) cyc();
      chk8("arst.pre", 1, 1'b1, 1'b0);
      cv8 = 1'b1; cb8 = 8'h33;
      cyc();
      cv8 = 1'b0;
      chk("arst.pending", 32'(ready8), 32'd0);
      #2;
      rst_n_i = 1'b0;
      #1;
      chk8("arst.now", 0, 1'b0, 1'b0);
      chk("arst.now.ready", 32'(ready8), 32'd1);
      chk("arst.now.pwm",   32'(pwm8),   32'(PWM_RST));
      en8 = 1'b0;
      cyc();
      rst_n_i = 1'b1;
      cyc(); cyc(); cyc();
      chk("arst.post.pwm",   32'(pwm8),   32'(PWM_RST));
      chk("arst.post.ready", 32'(ready8), 32'd1);

      // NUM_LEDS=1, step_period=0: tick every cycle
      do_reset();
      md1 = 2'b00; per1 = 24'd0; en1 = 1'b1;
      cyc();
      chk("n1.entry.sweep", 32'(sw1),  32'd0);
      chk("n1.entry.sel",   32'(sel1), 32'd1);
      for (int k = 1; k < 5; k++) begin
         cyc();
         chk($sformatf("n1.wrap[%0d].sweep", k), 32'(sw1),   32'd1);
         chk($sformatf("n1.wrap[%0d].pos", k),   32'(pos1),  32'd0);
         chk($sformatf("n1.wrap[%0d].busy", k),  32'(busy1), 32'd1);
      end
      md1 = 2'b11;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk($sformatf("n1.hold[%0d].sweep", k), 32'(sw1),  32'd0);
         chk($sformatf("n1.hold[%0d].sel", k),   32'(sel1), 32'd1);
      end
      md1 = 2'b01;
      cyc();
      chk("n1.bounce.sweep", 32'(sw1),  32'd1);
      chk("n1.bounce.pos",   32'(pos1), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
